audio_clk_gen: RTL and testbench

Synthesisable, parametrised clock generator for the WM8731 codec interface. From the single 50 MHz system clock it derives a phase-locked family of codec clocks: MCLK, BCLK and LRCLK. Alongside them it produces one-cycle strobes that the serialiser and deserialiser use to launch and capture data. It replaces simulation-only clock models and sits between the top-level clock/reset and the audio data path.

---
 rtl/audio_clk_gen.sv | 138 +++++++++++++
 tb/tb_audio_clk_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/audio_clk_gen.sv
// audio_clk_gen
// Derives the WM8731 codec clock family (MCLK, BCLK, LRCLK) from the system
// clock, together with one-cycle strobes that the serialiser and deserialiser
// use to launch and capture data. All outputs are registered and zero while idle.
//
// Ports:
//   Clk         system clock (50 MHz)
//   Rst_n       asynchronous active-low reset
//   Enable      run request, sampled on every rising Clk edge
//   Mclk        codec master clock, MCLK_DIV system cycles per period
//   Bclk        bit clock, BCLK_DIV system cycles per period
//   Lrclk       frame clock, 0 = left channel, 1 = right channel
//   BclkRise    strobe in the first cycle with Bclk high
//   BclkFall    strobe in the first cycle of each bit period (Bclk low)
//   FrameStart  strobe in the first cycle of each left+right frame
//   BitIdx      bit index within the current channel word
//   Running     registered copy of Enable
module audio_clk_gen #(
  parameter int unsigned MCLK_DIV  = 4,
  parameter int unsigned BCLK_DIV  = 8,
  parameter int unsigned WORD_BITS = 32
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Enable,
  output logic       Mclk,
  output logic       Bclk,
  output logic       Lrclk,
  output logic       BclkRise,
  output logic       BclkFall,
  output logic       FrameStart,
  output logic [4:0] BitIdx,
  output logic       Running
);

  if (MCLK_DIV < 2 || (MCLK_DIV % 2) != 0) begin : g_bad_mclk_div
    $error("audio_clk_gen: MCLK_DIV must be even and >= 2");
  end
  if (BCLK_DIV < 2 || (BCLK_DIV % 2) != 0) begin : g_bad_bclk_div
    $error("audio_clk_gen: BCLK_DIV must be even and >= 2");
  end
  if (WORD_BITS < 1 || WORD_BITS > 32) begin : g_bad_word_bits
    $error("audio_clk_gen: WORD_BITS must be in 1..32");
  end

  localparam int unsigned MW = $clog2(MCLK_DIV);
  localparam int unsigned BW = $clog2(BCLK_DIV);
  localparam int unsigned WW = $clog2(2 * WORD_BITS);

  localparam logic [MW-1:0] M_LAST = MW'(MCLK_DIV - 1);
  localparam logic [MW-1:0] M_HALF = MW'(MCLK_DIV / 2);
  localparam logic [BW-1:0] B_LAST = BW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] B_HALF = BW'(BCLK_DIV / 2);
  localparam logic [WW-1:0] W_LAST = WW'(2 * WORD_BITS - 1);
  localparam logic [WW-1:0] W_HALF = WW'(WORD_BITS);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state;

  logic [MW-1:0] mclk_cnt, mclk_nxt;
  logic [BW-1:0] bclk_cnt, bclk_nxt;
  logic [WW-1:0] bit_cnt,  bit_nxt;
  logic          lr_nxt;
  logic [WW-1:0] idx_nxt;

  // Next counter values describe the cycle being entered. Leaving IDLE they
  // are all zero, which makes the first enabled edge n=0.
  always_comb begin
    mclk_nxt = '0;
    bclk_nxt = '0;
    bit_nxt  = '0;
    if (state == RUN) begin
      mclk_nxt = (mclk_cnt == M_LAST) ? '0 : mclk_cnt + 1'b1;
      bclk_nxt = (bclk_cnt == B_LAST) ? '0 : bclk_cnt + 1'b1;
      if (bclk_cnt == B_LAST) begin
        bit_nxt = (bit_cnt == W_LAST) ? '0 : bit_cnt + 1'b1;
      end else begin
        bit_nxt = bit_cnt;
      end
    end
  end

  // bit_cnt spans both channels: the upper half is the right channel, so the
  // word index is bit_cnt with WORD_BITS removed in that half.
  always_comb begin
    lr_nxt  = (bit_nxt >= W_HALF);
    idx_nxt = lr_nxt ? (bit_nxt - W_HALF) : bit_nxt;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      mclk_cnt   <= '0;
      bclk_cnt   <= '0;
      bit_cnt    <= '0;
      Mclk       <= 1'b0;
      Bclk       <= 1'b0;
      Lrclk      <= 1'b0;
      BclkRise   <= 1'b0;
      BclkFall   <= 1'b0;
      FrameStart <= 1'b0;
      BitIdx     <= '0;
      Running    <= 1'b0;
    end else if (!Enable) begin
      // Abort without completing the frame; the next run restarts at n=0.
      state      <= IDLE;
      mclk_cnt   <= '0;
      bclk_cnt   <= '0;
      bit_cnt    <= '0;
      Mclk       <= 1'b0;
      Bclk       <= 1'b0;
      Lrclk      <= 1'b0;
      BclkRise   <= 1'b0;
      BclkFall   <= 1'b0;
      FrameStart <= 1'b0;
      BitIdx     <= '0;
      Running    <= 1'b0;
    end else begin
      state      <= RUN;
      mclk_cnt   <= mclk_nxt;
      bclk_cnt   <= bclk_nxt;
      bit_cnt    <= bit_nxt;
      Mclk       <= (mclk_nxt < M_HALF);
      Bclk       <= (bclk_nxt >= B_HALF);
      Lrclk      <= lr_nxt;
      BclkRise   <= (bclk_nxt == B_HALF);
      BclkFall   <= (bclk_nxt == '0);
      FrameStart <= (bclk_nxt == '0) && (bit_nxt == '0);
      BitIdx     <= 5'(idx_nxt);
      Running    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_audio_clk_gen.sv
// Bench for audio_clk_gen: two instances (default parameters and
// MCLK_DIV=2/BCLK_DIV=16/WORD_BITS=24) share clock, reset and Enable.
// Outputs are packed as {Mclk,Bclk,Lrclk,BclkRise,BclkFall,FrameStart,BitIdx,Running}.
module tb_audio_clk_gen;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Enable = 1'b0;

  logic       mclk_a, bclk_a, lrclk_a, rise_a, fall_a, fs_a, run_a;
  logic [4:0] idx_a;
  logic       mclk_b, bclk_b, lrclk_b, rise_b, fall_b, fs_b, run_b;
  logic [4:0] idx_b;

  logic [11:0] out_a, out_b;
  assign out_a = {mclk_a, bclk_a, lrclk_a, rise_a, fall_a, fs_a, idx_a, run_a};
  assign out_b = {mclk_b, bclk_b, lrclk_b, rise_b, fall_b, fs_b, idx_b, run_b};

  always #5 Clk = ~Clk;

  audio_clk_gen dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .Enable(Enable),
    .Mclk(mclk_a), .Bclk(bclk_a), .Lrclk(lrclk_a),
    .BclkRise(rise_a), .BclkFall(fall_a), .FrameStart(fs_a),
    .BitIdx(idx_a), .Running(run_a)
  );

  audio_clk_gen #(.MCLK_DIV(2), .BCLK_DIV(16), .WORD_BITS(24)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .Enable(Enable),
    .Mclk(mclk_b), .Bclk(bclk_b), .Lrclk(lrclk_b),
    .BclkRise(rise_b), .BclkFall(fall_b), .FrameStart(fs_b),
    .BitIdx(idx_b), .Running(run_b)
  );

  int tests = 0;
  int fails = 0;

  // Reference state: whether running, and n for the cycle after the last edge.
  bit m_run = 1'b0;
  int m_n   = 0;

  typedef struct {
    bit          inst_b;
    int          n;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [11:0] mk(input bit m, input bit b, input bit l,
                                     input bit r, input bit f, input bit s,
                                     input int idx);
    return {m, b, l, r, f, s, 5'(idx), 1'b1};
  endfunction

  function automatic logic [11:0] model(input int md, input int bd, input int wb,
                                        input bit run, input int n);
    int b;
    if (!run) return '0;
    b = (n / bd) % (2 * wb);
    return mk((n % md) < (md / 2), (n % bd) >= (bd / 2), b >= wb,
              (n % bd) == (bd / 2), (n % bd) == 0, (n % (bd * 2 * wb)) == 0,
              b % wb);
  endfunction

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s n=%0d run=%0d got=%h expected=%h", nm, m_n, m_run, act, exp);
    end
  endtask

  // Drive Enable, let one edge sample it, then compare both instances mid-cycle.
  task automatic step(input logic en);
    Enable = en;
    @(posedge Clk);
    if (en) begin
      m_n   = m_run ? m_n + 1 : 0;
      m_run = 1'b1;
    end else begin
      m_run = 1'b0;
      m_n   = 0;
    end
    @(negedge Clk);
    chk("model_a", out_a, model(4, 8, 32, m_run, m_n));
    chk("model_b", out_b, model(2, 16, 24, m_run, m_n));
  endtask

  initial begin
    int hits;

    tbl.push_back('{0, 0,    mk(1,0,0,0,1,1,0)});
    tbl.push_back('{0, 1,    mk(1,0,0,0,0,0,0)});
    tbl.push_back('{0, 2,    mk(0,0,0,0,0,0,0)});
    tbl.push_back('{0, 4,    mk(1,1,0,1,0,0,0)});
    tbl.push_back('{0, 7,    mk(0,1,0,0,0,0,0)});
    tbl.push_back('{0, 8,    mk(1,0,0,0,1,0,1)});
    tbl.push_back('{0, 255,  mk(0,1,0,0,0,0,31)});
    tbl.push_back('{0, 256,  mk(1,0,1,0,1,0,0)});
    tbl.push_back('{0, 260,  mk(1,1,1,1,0,0,0)});
    tbl.push_back('{0, 511,  mk(0,1,1,0,0,0,31)});
    tbl.push_back('{0, 512,  mk(1,0,0,0,1,1,0)});
    tbl.push_back('{0, 1024, mk(1,0,0,0,1,1,0)});
    tbl.push_back('{0, 1099, mk(0,0,0,0,0,0,9)});
    tbl.push_back('{1, 0,    mk(1,0,0,0,1,1,0)});
    tbl.push_back('{1, 1,    mk(0,0,0,0,0,0,0)});
    tbl.push_back('{1, 8,    mk(1,1,0,1,0,0,0)});
    tbl.push_back('{1, 16,   mk(1,0,0,0,1,0,1)});
    tbl.push_back('{1, 383,  mk(0,1,0,0,0,0,23)});
    tbl.push_back('{1, 384,  mk(1,0,1,0,1,0,0)});
    tbl.push_back('{1, 767,  mk(0,1,1,0,0,0,23)});
    tbl.push_back('{1, 768,  mk(1,0,0,0,1,1,0)});

    // Reset held with Enable high: everything stays zero.
    Rst_n  = 1'b0;
    Enable = 1'b1;
    repeat (3) @(negedge Clk);
    chk("reset_a", out_a, 12'h000);
    chk("reset_b", out_b, 12'h000);
    Rst_n = 1'b1;

    // Continuous run with table spot checks.
    hits = 0;
    for (int c = 0; c < 1100; c++) begin
      step(1'b1);
      for (int i = 0; i < tbl.size(); i++) begin
        if (tbl[i].n == m_n) begin
          hits++;
          chk(tbl[i].inst_b ? "table_b" : "table_a",
              tbl[i].inst_b ? out_b : out_a, tbl[i].exp);
        end
      end
    end
    tests++;
    if (hits != tbl.size()) begin
      fails++;
      $display("FAIL table_hits got=%0d expected=%0d", hits, tbl.size());
    end

    // Mid-frame abort at n=300, then restart from scratch.
    step(1'b0);
    for (int c = 0; c <= 300; c++) step(1'b1);
    step(1'b0);
    chk("abort_a", out_a, 12'h000);
    chk("abort_b", out_b, 12'h000);
    repeat (4) step(1'b0);
    step(1'b1);
    chk("restart_a", out_a, mk(1,0,0,0,1,1,0));
    chk("restart_b", out_b, mk(1,0,0,0,1,1,0));

    // Asynchronous reset between edges while running.
    repeat (50) step(1'b1);
    #2 Rst_n = 1'b0;
    #1;
    chk("async_rst_a", out_a, 12'h000);
    chk("async_rst_b", out_b, 12'h000);
    @(negedge Clk);
    chk("rst_hold_a", out_a, 12'h000);
    chk("rst_hold_b", out_b, 12'h000);
    Rst_n = 1'b1;
    m_run = 1'b0;
    m_n   = 0;
    step(1'b1);
    chk("post_rst_a", out_a, mk(1,0,0,0,1,1,0));

    // Randomized Enable pattern against the reference model.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 99) < 93);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
